uart_alu_controller: RTL

//  Sequencer between the UART receiver, the combinational ALU and the UART transmitter.
//  - Collects three received bytes in order: operand A, operand B, opcode.
//  - Drives the ALU with the collected values, latches the ALU result, hands it to the TX.
//  - Aborts an incomplete frame on an inter-byte timeout.
//  - Flags any byte that arrives while a result is still being sent.

---
 rtl/uart_alu_controller.sv | 129 ++++++++++++
 1 files changed

// File: rtl/uart_alu_controller.sv
// Frame sequencer between UART RX, combinational ALU and UART TX.
// Collects A, B and opcode bytes, latches the ALU result, starts TX, and aborts stalled frames.
module uart_alu_controller #(
    parameter int DATA_WIDTH     = 8,
    parameter int OP_WIDTH       = 6,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_rx_done,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    output logic [OP_WIDTH-1:0]   o_alu_op,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    output logic                  o_tx_start,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    input  logic                  i_tx_done,
    output logic                  o_busy,
    output logic                  o_timeout_err,
    output logic                  o_overrun
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_WAIT_A  = 3'd0,
        S_WAIT_B  = 3'd1,
        S_WAIT_OP = 3'd2,
        S_EXEC    = 3'd3,
        S_START   = 3'd4,
        S_WAIT_TX = 3'd5
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_alu_a;
    logic [DATA_WIDTH-1:0] r_alu_b;
    logic [OP_WIDTH-1:0]   r_alu_op;
    logic [DATA_WIDTH-1:0] r_tx_data;
    logic                  r_timeout_err;
    logic                  r_overrun;
    logic                  w_expired;

    assign w_expired = (r_cnt == CNT_MAX);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_WAIT_A;
            r_cnt         <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_op      <= '0;
            r_tx_data     <= '0;
            r_timeout_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                S_WAIT_A: begin
                    r_cnt <= '0;
                    if (i_rx_done) begin
                        r_alu_a   <= i_rx_data;
                        r_overrun <= 1'b0;
                        r_state   <= S_WAIT_B;
                    end
                end
                // A byte arriving on the expiry cycle is accepted; the timeout only fires on silence.
                S_WAIT_B: begin
                    if (i_rx_done) begin
                        r_alu_b <= i_rx_data;
                        r_cnt   <= '0;
                        r_state <= S_WAIT_OP;
                    end else if (w_expired) begin
                        r_cnt         <= '0;
                        r_timeout_err <= 1'b1;
                        r_state       <= S_WAIT_A;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_OP: begin
                    if (i_rx_done) begin
                        r_alu_op <= i_rx_data[OP_WIDTH-1:0];
                        r_cnt    <= '0;
                        r_state  <= S_EXEC;
                    end else if (w_expired) begin
                        r_cnt         <= '0;
                        r_timeout_err <= 1'b1;
                        r_state       <= S_WAIT_A;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    r_cnt     <= '0;
                    r_tx_data <= i_alu_result;
                    r_state   <= S_START;
                    if (i_rx_done) r_overrun <= 1'b1;
                end
                S_START: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_TX;
                    if (i_rx_done) r_overrun <= 1'b1;
                end
                S_WAIT_TX: begin
                    r_cnt <= '0;
                    if (i_rx_done) r_overrun <= 1'b1;
                    if (i_tx_done) r_state <= S_WAIT_A;
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_A;
                end
            endcase
        end
    end

    assign o_alu_a       = r_alu_a;
    assign o_alu_b       = r_alu_b;
    assign o_alu_op      = r_alu_op;
    assign o_tx_data     = r_tx_data;
    assign o_tx_start    = (r_state == S_START);
    assign o_busy        = (r_state != S_WAIT_A);
    assign o_timeout_err = r_timeout_err;
    assign o_overrun     = r_overrun;

endmodule
